sseg_display_ctrl: RTL and testbench

- Sequences the four-digit 7-segment display path. It generates the multiplex refresh clock and converts the binary temperature into the two-digit BCD word with a sequential double-dabble engine.
- It arbitrates between the temperature source and an alert source, with alert having priority, and drives the display enable.
- It sits between the temperature sensing logic and the segment display driver, which consumes displayCLK, display and decimalTemp.

---
 rtl/sseg_display_ctrl_pkg.sv | 40 ++++
 rtl/bin_to_bcd_seq.sv | 73 +++++++
 rtl/sseg_display_ctrl.sv | 142 ++++++++++++++
 tb/tb_sseg_display_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_display_ctrl_pkg.sv
// Shared encodings, glyph constants and double-dabble helpers for the 7-segment display path.
package sseg_display_ctrl_pkg;

    localparam int unsigned BIN_W  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BCD_W  = 3 * NIB_W;
    localparam int unsigned ITER_W = 3;

    localparam logic [ITER_W-1:0] ITER_LAST     = ITER_W'(BIN_W - 1);
    localparam logic [7:0]        BLANK_BCD     = 8'hFF;
    localparam logic [7:0]        OVR_BCD       = 8'hAA;
    localparam logic [NIB_W-1:0]  BCD_BLANK_NIB = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } conv_state_e;

    typedef struct packed {
        logic [NIB_W-1:0] hund;
        logic [NIB_W-1:0] tens;
        logic [NIB_W-1:0] ones;
    } bcd3_t;

    // Add-3 correction applied to a digit before it is doubled by the shift.
    function automatic logic [NIB_W-1:0] dd_fix(input logic [NIB_W-1:0] nib);
        return (nib >= NIB_W'(5)) ? nib + NIB_W'(3) : nib;
    endfunction

    function automatic bcd3_t dd_adjust(input bcd3_t b);
        bcd3_t r;
        r.hund = dd_fix(b.hund);
        r.tens = dd_fix(b.tens);
        r.ones = dd_fix(b.ones);
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD, one shift per cycle.
module bin_to_bcd_seq
    import sseg_display_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] operand,
    output logic             idle_c,
    output logic             done_c,
    output logic [BCD_W-1:0] result
);

    conv_state_e      state_q, state_d;
    bcd3_t            bcd_q, bcd_d, bcd_adj;
    logic [BIN_W-1:0] sh_q, sh_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            sh_q    <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            sh_q    <= sh_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        iter_d  = iter_q;
        bcd_adj = dd_adjust(bcd_q);
        idle_c  = 1'b0;
        done_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                idle_c = 1'b1;
                if (start) begin
                    sh_d    = operand;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = '0;
                iter_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Correct then double in the same cycle; the binary MSB enters the ones digit.
                {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                iter_d        = iter_q + ITER_W'(1);
                if (iter_q == ITER_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = bcd_q;

endmodule

// File: rtl/sseg_display_ctrl.sv
// Display sequencer: refresh prescaler, temperature-to-BCD conversion with one-deep
// buffering, alert arbitration with hold time, and the registered output mux.
module sseg_display_ctrl
    import sseg_display_ctrl_pkg::*;
#(
    parameter int unsigned DIV_BIT    = 17,
    parameter int unsigned BLINK_BIT  = 25,
    parameter int unsigned HOLD_TICKS = 381
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [BIN_W-1:0] tempBin,
    input  logic             tempValid,
    input  logic             alertReq,
    input  logic [3:0]       alertCode,
    input  logic             enable,
    output logic             displayCLK,
    output logic             display,
    output logic [7:0]       decimalTemp,
    output logic             busy,
    output logic             alertActive
);

    localparam int unsigned PRESC_W = BLINK_BIT + 1;
    localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);

    logic [PRESC_W-1:0] prescaler;
    logic               dclk_q;
    logic               tick_c;

    logic               pend_q, pend_d;
    logic [BIN_W-1:0]   pend_val_q, pend_val_d;

    logic               conv_start_c;
    logic [BIN_W-1:0]   conv_operand_c;
    logic               conv_idle_c;
    logic               conv_done_c;
    logic [BCD_W-1:0]   conv_result;
    bcd3_t              conv_bcd;

    logic [7:0]         temp_word_q;
    logic [HOLD_W-1:0]  hold_q;

    // Free-running prescaler; displayCLK is a straight tap, tick marks its rising edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            dclk_q    <= 1'b0;
        end else begin
            prescaler <= prescaler + PRESC_W'(1);
            dclk_q    <= prescaler[DIV_BIT];
        end
    end

    assign displayCLK = prescaler[DIV_BIT];
    assign tick_c     = prescaler[DIV_BIT] & ~dclk_q;

    // A held operand is converted before a fresh strobe; a strobe arriving while busy overwrites it.
    always_comb begin
        pend_d         = pend_q;
        pend_val_d     = pend_val_q;
        conv_start_c   = 1'b0;
        conv_operand_c = tempBin;

        if (conv_idle_c) begin
            if (pend_q) begin
                conv_start_c   = 1'b1;
                conv_operand_c = pend_val_q;
                pend_d         = tempValid;
                if (tempValid) begin
                    pend_val_d = tempBin;
                end
            end else if (tempValid) begin
                conv_start_c = 1'b1;
            end
        end else if (tempValid) begin
            pend_d     = 1'b1;
            pend_val_d = tempBin;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            busy       <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            busy       <= (conv_idle_c ? conv_start_c : ~conv_done_c) | pend_d;
        end
    end

    bin_to_bcd_seq u_bin_to_bcd (
        .CLK     (CLK),
        .reset   (reset),
        .start   (conv_start_c),
        .operand (conv_operand_c),
        .idle_c  (conv_idle_c),
        .done_c  (conv_done_c),
        .result  (conv_result)
    );

    assign conv_bcd = conv_result;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            temp_word_q <= BLANK_BCD;
        end else if (conv_done_c) begin
            temp_word_q <= (conv_bcd.hund != '0) ? OVR_BCD : {conv_bcd.tens, conv_bcd.ones};
        end
    end

    // Alert owns the display while requested and for HOLD_TICKS refresh ticks afterwards.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            alertActive <= 1'b0;
            hold_q      <= '0;
        end else if (alertReq) begin
            alertActive <= 1'b1;
            hold_q      <= HOLD_W'(HOLD_TICKS);
        end else if (alertActive && tick_c) begin
            if (hold_q <= HOLD_W'(1)) begin
                hold_q      <= '0;
                alertActive <= 1'b0;
            end else begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            decimalTemp <= BLANK_BCD;
            display     <= 1'b0;
        end else begin
            decimalTemp <= alertActive ? {alertCode, BCD_BLANK_NIB} : temp_word_q;
            display     <= enable & (~alertActive | prescaler[BLINK_BIT]);
        end
    end

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Directed bench for sseg_display_ctrl, run with shortened prescaler taps and hold count.
module tb_sseg_display_ctrl;

    localparam int unsigned TB_DIV   = 3;
    localparam int unsigned TB_BLINK = 5;
    localparam int unsigned TB_HOLD  = 4;

    logic       CLK;
    logic       reset;
    logic [7:0] tempBin;
    logic       tempValid;
    logic       alertReq;
    logic [3:0] alertCode;
    logic       enable;
    logic       displayCLK;
    logic       display;
    logic [7:0] decimalTemp;
    logic       busy;
    logic       alertActive;

    int checks = 0;
    int errors = 0;

    logic [TB_BLINK:0] presc_m;
    logic [TB_BLINK:0] prev_presc;
    logic              prev_aa;
    logic              prev_dclk;

    sseg_display_ctrl #(
        .DIV_BIT    (TB_DIV),
        .BLINK_BIT  (TB_BLINK),
        .HOLD_TICKS (TB_HOLD)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .tempBin     (tempBin),
        .tempValid   (tempValid),
        .alertReq    (alertReq),
        .alertCode   (alertCode),
        .enable      (enable),
        .displayCLK  (displayCLK),
        .display     (display),
        .decimalTemp (decimalTemp),
        .busy        (busy),
        .alertActive (alertActive)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference free-running counter for the prescaler taps.
    always @(posedge CLK or posedge reset) begin
        if (reset) presc_m <= '0;
        else       presc_m <= presc_m + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        prev_aa    = alertActive;
        prev_presc = presc_m;
        prev_dclk  = displayCLK;
        @(posedge CLK);
        #1;
    endtask

    task automatic conv(input string tag, input logic [7:0] v, input logic [7:0] exp);
        tempBin   = v;
        tempValid = 1'b1;
        step();
        tempValid = 1'b0;
        repeat (11) step();
        check(tag, decimalTemp, exp);
        check({tag, "_busy"}, busy, 0);
    endtask

    int  ticks;
    int  r1, r2;
    bit  saw41, saw88, saw_d0, saw_d1, disp_hi;

    initial begin
        reset     = 1'b1;
        tempBin   = '0;
        tempValid = 1'b0;
        alertReq  = 1'b0;
        alertCode = '0;
        enable    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_dt",    decimalTemp, 8'hFF);
        check("rst_busy",  busy, 0);
        check("rst_alert", alertActive, 0);
        check("rst_disp",  display, 0);
        check("rst_dclk",  displayCLK, 0);

        reset = 1'b0;
        step();
        check("disp_on", display, 1);
        check("idle_dt", decimalTemp, 8'hFF);

        // Latency: busy for 10 cycles, word visible on the 11th edge.
        tempBin   = 8'd37;
        tempValid = 1'b1;
        step();
        tempValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("lat_busy", busy, 1);
            check("lat_blank", decimalTemp, 8'hFF);
            step();
        end
        check("lat_busy_lo", busy, 0);
        check("lat_pre", decimalTemp, 8'hFF);
        step();
        check("lat_37", decimalTemp, 8'h37);
        check("lat_busy_end", busy, 0);

        conv("conv99",  8'd99,  8'h99);
        conv("conv100", 8'd100, 8'hAA);
        conv("conv255", 8'd255, 8'hAA);
        conv("conv0",   8'd0,   8'h00);

        // Pending buffer: 25 at cycle 0, 41 at 3, 63 at 5; only 25 and 63 appear.
        saw41 = 0;
        for (int c = 0; c < 24; c++) begin
            tempValid = (c == 0) || (c == 3) || (c == 5);
            tempBin   = (c == 0) ? 8'd25 : (c == 3) ? 8'd41 : 8'd63;
            step();
            tempValid = 1'b0;
            if (decimalTemp == 8'h41) saw41 = 1;
            if (c <= 20) check("pend_busy", busy, 1);
            if (c == 21) check("pend_busy_lo", busy, 0);
            if (c == 10) check("pend_pre", decimalTemp, 8'h00);
            if (c == 11) check("pend_25", decimalTemp, 8'h25);
            if (c == 21) check("pend_hold25", decimalTemp, 8'h25);
            if (c == 22) check("pend_63", decimalTemp, 8'h63);
        end
        check("pend_no41", saw41, 0);

        conv("conv37", 8'd37, 8'h37);

        // Alert with code 11 for 5 cycles, then hold for TB_HOLD refresh ticks.
        alertCode = 4'd11;
        alertReq  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) check("alert_set", alertActive, 1);
        end
        check("alert_bf", decimalTemp, 8'hBF);
        alertReq = 1'b0;
        ticks  = 0;
        saw_d0 = 0;
        saw_d1 = 0;
        for (int i = 0; i < 200 && alertActive; i++) begin
            if (displayCLK && !prev_dclk) ticks++;
            step();
            check("alert_disp", display, enable & (~prev_aa | prev_presc[TB_BLINK]));
            if (prev_aa) begin
                if (display) saw_d1 = 1;
                else         saw_d0 = 1;
            end
        end
        check("alert_rel", alertActive, 0);
        check("alert_ticks", ticks, TB_HOLD);
        check("alert_blink", {saw_d0, saw_d1}, 2'b11);
        step();
        check("alert_back37", decimalTemp, 8'h37);
        check("dclk_tap", displayCLK, presc_m[TB_DIV]);

        // Asynchronous reset in the middle of converting 88.
        tempBin   = 8'd88;
        tempValid = 1'b1;
        step();
        tempValid = 1'b0;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        check("arst_dt",    decimalTemp, 8'hFF);
        check("arst_busy",  busy, 0);
        check("arst_alert", alertActive, 0);
        check("arst_disp",  display, 0);
        check("arst_dclk",  displayCLK, 0);
        step();
        reset = 1'b0;
        saw88 = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (decimalTemp == 8'h88) saw88 = 1;
        end
        check("arst_no88", saw88, 0);
        check("arst_blank", decimalTemp, 8'hFF);
        check("arst_busy_lo", busy, 0);

        // enable low blanks the display only.
        enable = 1'b0;
        step();
        tempBin   = 8'd52;
        tempValid = 1'b1;
        disp_hi = 0;
        r1 = -1;
        r2 = -1;
        for (int c = 0; c < 60; c++) begin
            step();
            tempValid = 1'b0;
            if (display) disp_hi = 1;
            if (displayCLK && !prev_dclk) begin
                if (r1 < 0)      r1 = c;
                else if (r2 < 0) r2 = c;
            end
        end
        check("en0_disp", disp_hi, 0);
        check("en0_52", decimalTemp, 8'h52);
        check("en0_period", r2 - r1, 32'd1 << (TB_DIV + 1));
        check("en0_dclk_tap", displayCLK, presc_m[TB_DIV]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
